// File: rtl/rope_bitmap_anim.sv
// Animated rope texture: tile mask lookup with scroll, colour modes and flash.
// Two-stage pipeline from offsets to RGBout/drawingRequest.
module rope_bitmap_anim #(
    parameter int TILE_W = 7,
    parameter int TILE_H = 8,
    parameter int Y_SCALE_LOG2 = 1,
    parameter logic [TILE_H*TILE_W-1:0] PATTERN = {
        7'h0E, 7'h07, 7'h0E, 7'h1C,
        7'h38, 7'h70, 7'h38, 7'h1C
    },
    parameter int SCROLL_DIV = 4,
    parameter int FLASH_PERIOD = 8,
    parameter logic [7:0] FLASH_COLOR = 8'hB6
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        InsideRectangle,
    input  logic [1:0]  mode,
    input  logic        startOfFrame,
    input  logic        flashEn,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);
    localparam logic [PW-1:0] FLASH_LAST = PW'(FLASH_PERIOD - 1);

    logic [1:0]         modeReg;
    logic [FW-1:0]      frameCnt;
    logic [RW-1:0]      phase;
    logic [PW-1:0]      flashCnt;
    logic               flashBit;
    logic               hit;
    logic [RW-1:0]      row;
    logic [(1<<CW)-1:0] row_bits;
    logic               in_x;
    logic               hit_d;
    logic [7:0]         pal;

    // Row bits padded to a power of two so the column index never overruns.
    always_comb begin
        row = RW'(offsetY >> Y_SCALE_LOG2) + phase;
        row_bits = '0;
        row_bits[TILE_W-1:0] = PATTERN[int'(row)*TILE_W +: TILE_W];
        in_x = offsetX < 11'(TILE_W);
        hit_d = InsideRectangle && in_x && row_bits[offsetX[CW-1:0]];
    end

    always_comb begin
        pal = 8'h1C;
        unique case (modeReg)
            2'd0: pal = 8'h1C;
            2'd1: pal = 8'hE0;
            2'd2: pal = 8'h03;
            2'd3: pal = 8'hFC;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            modeReg  <= '0;
            frameCnt <= '0;
            phase    <= '0;
        end else if (startOfFrame) begin
            modeReg <= mode;
            if (SCROLL_DIV != 0) begin
                if (frameCnt == FRAME_LAST) begin
                    frameCnt <= '0;
                    phase    <= phase + 1'b1;
                end else begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flashCnt <= '0;
            flashBit <= 1'b0;
        end else if (!flashEn) begin
            flashCnt <= '0;
            flashBit <= 1'b0;
        end else if (startOfFrame) begin
            if (flashCnt == FLASH_LAST) begin
                flashCnt <= '0;
                flashBit <= ~flashBit;
            end else begin
                flashCnt <= flashCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hit    <= 1'b0;
            RGBout <= 8'hFF;
        end else begin
            hit <= hit_d;
            if (hit && flashBit)
                RGBout <= FLASH_COLOR;
            else if (hit)
                RGBout <= pal;
            else
                RGBout <= 8'hFF;
        end
    end

    assign drawingRequest = (RGBout != 8'hFF);

endmodule

// File: tb/tb_rope_bitmap_anim.sv
// Scoreboard bench for rope_bitmap_anim: mask, modes, scroll, flash, reset.
module tb_rope_bitmap_anim;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [1:0]  mode;
    logic        startOfFrame;
    logic        flashEn;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    always #5 clk = ~clk;

    rope_bitmap_anim dut (
        .clk(clk),
        .resetN(resetN),
        .offsetX(offsetX),
        .offsetY(offsetY),
        .InsideRectangle(InsideRectangle),
        .mode(mode),
        .startOfFrame(startOfFrame),
        .flashEn(flashEn),
        .drawingRequest(drawingRequest),
        .RGBout(RGBout)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    string tag_q[$];
    logic vin = 1'b0;
    logic v1 = 1'b0;
    logic v2 = 1'b0;

    int mode_m = 0;
    int phase_m = 0;
    int frame_m = 0;
    int fcnt_m = 0;
    logic flash_m = 1'b0;
    int lo_tab[8] = '{2, 3, 4, 3, 2, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pal_m(input int m);
        case (m)
            0: return 8'h1C;
            1: return 8'hE0;
            2: return 8'h03;
            default: return 8'hFC;
        endcase
    endfunction

    function automatic logic [7:0] exp_rgb(input int x, input int y,
                                           input logic ins);
        int r;
        bit h;
        r = ((y >> 1) + phase_m) % 8;
        h = ins && x < 7 && x >= lo_tab[r] && x <= lo_tab[r] + 2;
        if (!h) return 8'hFF;
        if (flash_m) return 8'hB6;
        return pal_m(mode_m);
    endfunction

    always @(posedge clk) begin
        v1 <= vin;
        v2 <= v1;
    end

    initial begin : monitor
        forever begin : mon_loop
            logic [7:0] e;
            string t;
            @(posedge clk);
            #1;
            if (v2) begin
                if (exp_q.size() == 0) begin
                    chk("underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    chk(t, RGBout, e);
                    chk({t, "_dr"}, drawingRequest, (e != 8'hFF));
                end
            end
        end
    end

    task automatic pix(input int x, input int y, input logic ins,
                       input string t);
        @(negedge clk);
        offsetX = 11'(x);
        offsetY = 11'(y);
        InsideRectangle = ins;
        vin = 1'b1;
        exp_q.push_back(exp_rgb(x, y, ins));
        tag_q.push_back($sformatf("%s_x%0d_y%0d", t, x, y));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vin = 1'b0;
        end
    endtask

    task automatic drain();
        idle(3);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic sof();
        @(negedge clk);
        vin = 1'b0;
        startOfFrame = 1'b1;
        mode_m = int'(mode);
        frame_m++;
        if (frame_m == 4) begin
            frame_m = 0;
            phase_m = (phase_m + 1) % 8;
        end
        if (flashEn) begin
            fcnt_m++;
            if (fcnt_m == 8) begin
                fcnt_m = 0;
                flash_m = ~flash_m;
            end
        end
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic sofs(input int n);
        repeat (n) sof();
    endtask

    task automatic sweep(input int y, input int xmax, input string t);
        for (int x = 0; x <= xmax; x++) pix(x, y, 1'b1, t);
        drain();
    endtask

    initial begin
        resetN = 1'b0;
        offsetX = 11'd2;
        offsetY = 11'd0;
        InsideRectangle = 1'b1;
        mode = 2'd0;
        startOfFrame = 1'b0;
        flashEn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", RGBout, 32'hFF);
        chk("rst_dr", drawingRequest, 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        pix(2, 0, 1'b1, "post_rst");
        drain();

        mode = 2'd1;
        sof();
        sweep(12, 10, "mask");

        mode = 2'd0;
        sof();
        mode = 2'd3;
        pix(2, 0, 1'b1, "mid_old");
        pix(4, 0, 1'b1, "mid_old");
        drain();
        sof();
        pix(2, 0, 1'b1, "mid_new");
        drain();

        sof();
        sweep(0, 6, "scroll1");
        sofs(28);
        sweep(0, 6, "scroll0");

        @(negedge clk);
        flashEn = 1'b1;
        sofs(8);
        sweep(0, 6, "flash_on");
        sofs(8);
        sweep(0, 6, "flash_off");
        sofs(8);
        sweep(2, 6, "flash_on2");
        @(negedge clk);
        flashEn = 1'b0;
        flash_m = 1'b0;
        fcnt_m = 0;
        sweep(2, 6, "flash_drop");

        for (int x = 0; x <= 6; x++) pix(x, 0, 1'b0, "outside");
        drain();

        @(negedge clk);
        offsetX = 11'd2;
        offsetY = 11'd0;
        InsideRectangle = 1'b1;
        vin = 1'b0;
        sofs(4 * (8 - phase_m) - frame_m);
        idle(3);
        chk("pre_rst", RGBout, exp_rgb(2, 0, 1'b1));
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_rst_rgb", RGBout, 32'hFF);
        chk("mid_rst_dr", drawingRequest, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        mode_m = 0;
        phase_m = 0;
        frame_m = 0;
        fcnt_m = 0;
        flash_m = 1'b0;
        pix(2, 0, 1'b1, "after_rst");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
